// File: rtl/dmem_arbiter.sv
// Two-requester arbiter in front of a fixed-latency data memory (IDLE/ACCESS/DONE).
// Define DMEM_ARB_RR_EN for round-robin tie-breaking; otherwise requester 0 always wins ties.
module dmem_arbiter #(
  parameter int LAT = 2
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        m0_req_i,
  input  logic        m0_we_i,
  input  logic [31:0] m0_addr_i,
  input  logic [31:0] m0_wdata_i,
  output logic        m0_ack_o,
  output logic [31:0] m0_rdata_o,
  input  logic        m1_req_i,
  input  logic        m1_we_i,
  input  logic [31:0] m1_addr_i,
  input  logic [31:0] m1_wdata_i,
  output logic        m1_ack_o,
  output logic [31:0] m1_rdata_o,
  output logic [31:0] mem_addr_o,
  output logic [31:0] mem_wdata_o,
  output logic        mem_read_o,
  output logic        mem_write_o,
  input  logic [31:0] mem_rdata_i,
  output logic        busy_o
);

  typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;

  localparam logic [3:0] CNT_INIT = 4'(LAT - 1);

  state_t      state;
  state_t      state_next;
  logic [3:0]  cnt;
  logic        gnt;
  logic        we;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [31:0] rdata0;
  logic [31:0] rdata1;
  logic        start;
  logic        pick;

`ifdef DMEM_ARB_RR_EN
  logic        last_grant;
`endif

  // Next state plus grant decision; pick is the winning requester index.
  always_comb begin
    state_next = state;
    start      = 1'b0;
    pick       = 1'b0;
    case (state)
      IDLE: begin
        if (m0_req_i || m1_req_i) begin
          start      = 1'b1;
          state_next = ACCESS;
`ifdef DMEM_ARB_RR_EN
          if (m0_req_i && m1_req_i)
            pick = ~last_grant;
          else
            pick = m1_req_i;
`else
          pick = ~m0_req_i;
`endif
        end
      end
      ACCESS: begin
        if (cnt == 4'd0)
          state_next = DONE;
      end
      DONE: begin
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state  <= IDLE;
      cnt    <= 4'd0;
      gnt    <= 1'b0;
      we     <= 1'b0;
      addr   <= 32'd0;
      wdata  <= 32'd0;
      rdata0 <= 32'd0;
      rdata1 <= 32'd0;
`ifdef DMEM_ARB_RR_EN
      last_grant <= 1'b1;
`endif
    end else begin
      state <= state_next;
      if (start) begin
        gnt   <= pick;
        we    <= pick ? m1_we_i    : m0_we_i;
        addr  <= pick ? m1_addr_i  : m0_addr_i;
        wdata <= pick ? m1_wdata_i : m0_wdata_i;
        cnt   <= CNT_INIT;
`ifdef DMEM_ARB_RR_EN
        last_grant <= pick;
`endif
      end else if (state == ACCESS) begin
        if (cnt != 4'd0) begin
          cnt <= cnt - 4'd1;
        end else if (!we) begin
          // Read data lands straight in the owner's register so it is valid in DONE.
          if (gnt)
            rdata1 <= mem_rdata_i;
          else
            rdata0 <= mem_rdata_i;
        end
      end
    end
  end

  assign mem_addr_o  = addr;
  assign mem_wdata_o = wdata;
  assign mem_read_o  = (state == ACCESS) && !we;
  assign mem_write_o = (state == ACCESS) && we && (cnt == 4'd0);
  assign m0_ack_o    = (state == DONE) && !gnt;
  assign m1_ack_o    = (state == DONE) && gnt;
  assign m0_rdata_o  = rdata0;
  assign m1_rdata_o  = rdata1;
  assign busy_o      = (state != IDLE);

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter: scoreboard of expected acks plus a small memory model.
// Main instance uses LAT=2; a second instance with LAT=1 covers the single-cycle access case.
module tb_dmem_arbiter;

  localparam int LAT = 2;

  typedef struct {
    int          port;
    logic [31:0] rdata;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;

  logic        m0_req, m0_we, m1_req, m1_we;
  logic [31:0] m0_addr, m0_wdata, m1_addr, m1_wdata;
  logic        m0_ack, m1_ack;
  logic [31:0] m0_rdata, m1_rdata;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic        mem_read, mem_write, busy;

  logic        b_m0_req, b_m0_we;
  logic [31:0] b_m0_addr, b_m0_wdata;
  logic        b_m0_ack, b_m1_ack;
  logic [31:0] b_m0_rdata, b_m1_rdata;
  logic [31:0] b_mem_addr, b_mem_wdata, b_mem_rdata;
  logic        b_mem_read, b_mem_write, b_busy;

  logic [31:0] mem_model [0:63];
  exp_t        sb [$];
  int          n_checks = 0;
  int          n_pass   = 0;
  int          n_fail   = 0;
  logic [31:0] last_wa, last_wd;

  always #5 clk = ~clk;

  assign mem_rdata   = mem_model[mem_addr[7:2]];
  assign b_mem_rdata = mem_model[b_mem_addr[7:2]];

  // Memory model: preloaded during reset, written by either instance's write strobe.
  always @(posedge clk) begin
    if (rst) begin
      mem_model[4]  <= 32'hDEADBEEF;
      mem_model[12] <= 32'h5A5A1234;
    end
    if (mem_write)   mem_model[mem_addr[7:2]]   <= mem_wdata;
    if (b_mem_write) mem_model[b_mem_addr[7:2]] <= b_mem_wdata;
  end

  dmem_arbiter #(.LAT(LAT)) u_dut (
    .clk_i(clk), .rst_i(rst),
    .m0_req_i(m0_req), .m0_we_i(m0_we), .m0_addr_i(m0_addr), .m0_wdata_i(m0_wdata),
    .m0_ack_o(m0_ack), .m0_rdata_o(m0_rdata),
    .m1_req_i(m1_req), .m1_we_i(m1_we), .m1_addr_i(m1_addr), .m1_wdata_i(m1_wdata),
    .m1_ack_o(m1_ack), .m1_rdata_o(m1_rdata),
    .mem_addr_o(mem_addr), .mem_wdata_o(mem_wdata),
    .mem_read_o(mem_read), .mem_write_o(mem_write),
    .mem_rdata_i(mem_rdata), .busy_o(busy)
  );

  dmem_arbiter #(.LAT(1)) u_dut_lat1 (
    .clk_i(clk), .rst_i(rst),
    .m0_req_i(b_m0_req), .m0_we_i(b_m0_we), .m0_addr_i(b_m0_addr), .m0_wdata_i(b_m0_wdata),
    .m0_ack_o(b_m0_ack), .m0_rdata_o(b_m0_rdata),
    .m1_req_i(1'b0), .m1_we_i(1'b0), .m1_addr_i(32'd0), .m1_wdata_i(32'd0),
    .m1_ack_o(b_m1_ack), .m1_rdata_o(b_m1_rdata),
    .mem_addr_o(b_mem_addr), .mem_wdata_o(b_mem_wdata),
    .mem_read_o(b_mem_read), .mem_write_o(b_mem_write),
    .mem_rdata_i(b_mem_rdata), .busy_o(b_busy)
  );

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("[TB] FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic drive_req(input int port, input logic we, input logic [31:0] addr,
                           input logic [31:0] wdata);
    if (port == 0) begin
      m0_req = 1'b1; m0_we = we; m0_addr = addr; m0_wdata = wdata;
    end else begin
      m1_req = 1'b1; m1_we = we; m1_addr = addr; m1_wdata = wdata;
    end
  endtask

  task automatic push_exp(input int port, input logic [31:0] rdata);
    exp_t e;
    e.port  = port;
    e.rdata = rdata;
    sb.push_back(e);
  endtask

  task automatic applyStimulus(input int port, input logic we, input logic [31:0] addr,
                               input logic [31:0] wdata, input logic [31:0] exp_rdata);
    drive_req(port, we, addr, wdata);
    push_exp(port, exp_rdata);
  endtask

  task automatic drop(input int port);
    if (port == 0) m0_req = 1'b0;
    else           m1_req = 1'b0;
  endtask

  // Waits (bounded) for the next ack, then compares it against the scoreboard head.
  task automatic checkAck(input int lat_exp, input int nrd_exp, input int nwr_exp);
    int   port, lat, nrd, nwr;
    exp_t e;
    port = -1; lat = 0; nrd = 0; nwr = 0;
    for (int k = 1; k <= 40; k++) begin
      @(posedge clk); @(negedge clk);
      if (mem_read) nrd++;
      if (mem_write) begin
        nwr++;
        last_wa = mem_addr;
        last_wd = mem_wdata;
      end
      if (m0_ack || m1_ack) begin
        port = (m0_ack && m1_ack) ? 2 : (m1_ack ? 1 : 0);
        lat  = k;
        break;
      end
    end
    if (sb.size() > 0) e = sb.pop_front();
    else begin
      e.port  = -1;
      e.rdata = 32'd0;
    end
    checkOutput("ack_port", 32'(port), 32'(e.port));
    checkOutput("ack_rdata", (e.port == 1) ? m1_rdata : m0_rdata, e.rdata);
    checkOutput("ack_latency", 32'(lat), 32'(lat_exp));
    checkOutput("read_strobes", 32'(nrd), 32'(nrd_exp));
    checkOutput("write_strobes", 32'(nwr), 32'(nwr_exp));
  endtask

  task automatic tick;
    @(posedge clk); @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not complete");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int stray;
    m0_req = 0; m0_we = 0; m0_addr = 0; m0_wdata = 0;
    m1_req = 0; m1_we = 0; m1_addr = 0; m1_wdata = 0;
    b_m0_req = 0; b_m0_we = 0; b_m0_addr = 0; b_m0_wdata = 0;
    last_wa = 0; last_wd = 0;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);

    $display("[TB] reset state");
    checkOutput("rst_busy", 32'(busy), 32'd0);
    checkOutput("rst_m0_ack", 32'(m0_ack), 32'd0);
    checkOutput("rst_m1_ack", 32'(m1_ack), 32'd0);
    checkOutput("rst_m0_rdata", m0_rdata, 32'd0);
    checkOutput("rst_m1_rdata", m1_rdata, 32'd0);
    checkOutput("rst_mem_addr", mem_addr, 32'd0);
    checkOutput("rst_mem_wdata", mem_wdata, 32'd0);
    checkOutput("rst_mem_read", 32'(mem_read), 32'd0);
    checkOutput("rst_mem_write", 32'(mem_write), 32'd0);
    rst = 1'b0;
    tick();

    $display("[TB] m0 read 0x10");
    applyStimulus(0, 1'b0, 32'h10, 32'd0, 32'hDEADBEEF);
    checkAck(LAT + 1, LAT, 0);
    drop(0);
    tick();
    checkOutput("ack_one_cycle", 32'(m0_ack), 32'd0);
    checkOutput("idle_busy", 32'(busy), 32'd0);
    checkOutput("idle_read_low", 32'(mem_read), 32'd0);
    checkOutput("addr_retained", mem_addr, 32'h10);

    $display("[TB] m1 write 0x20");
    applyStimulus(1, 1'b1, 32'h20, 32'h12345678, 32'd0);
    checkAck(LAT + 1, 0, 1);
    drop(1);
    checkOutput("write_addr", last_wa, 32'h20);
    checkOutput("write_data", last_wd, 32'h12345678);
    checkOutput("m0_rdata_kept", m0_rdata, 32'hDEADBEEF);
    checkOutput("mem_written", mem_model[8], 32'h12345678);
    tick();

    $display("[TB] m1 read back 0x20");
    applyStimulus(1, 1'b0, 32'h20, 32'd0, 32'h12345678);
    checkAck(LAT + 1, LAT, 0);
    drop(1);
    tick();

    $display("[TB] simultaneous requests, four grants");
    drive_req(0, 1'b0, 32'h10, 32'd0);
    drive_req(1, 1'b0, 32'h30, 32'd0);
    for (int i = 0; i < 4; i++) begin
`ifdef DMEM_ARB_RR_EN
      if (i % 2 == 0) push_exp(0, 32'hDEADBEEF);
      else            push_exp(1, 32'h5A5A1234);
`else
      push_exp(0, 32'hDEADBEEF);
`endif
    end
    checkAck(LAT + 1, LAT, 0);
    for (int i = 0; i < 3; i++) checkAck(LAT + 2, LAT, 0);
    drop(0);
    drop(1);
    tick();
    tick();
    checkOutput("arb_end_busy", 32'(busy), 32'd0);
`ifdef DMEM_ARB_RR_EN
    checkOutput("arb_m1_rdata", m1_rdata, 32'h5A5A1234);
`else
    checkOutput("arb_m1_starved", m1_rdata, 32'h12345678);
`endif

    $display("[TB] reset during ACCESS of a write");
    drive_req(0, 1'b1, 32'h24, 32'hCAFEF00D);
    tick();
    checkOutput("pre_rst_busy", 32'(busy), 32'd1);
    checkOutput("pre_rst_no_write", 32'(mem_write), 32'd0);
    checkOutput("pre_rst_addr", mem_addr, 32'h24);
    rst = 1'b1;
    drop(0);
    tick();
    checkOutput("abort_busy", 32'(busy), 32'd0);
    checkOutput("abort_ack", 32'({m0_ack, m1_ack}), 32'd0);
    checkOutput("abort_addr", mem_addr, 32'd0);
    checkOutput("abort_wdata", mem_wdata, 32'd0);
    checkOutput("abort_m0_rdata", m0_rdata, 32'd0);
    checkOutput("abort_write", 32'(mem_write), 32'd0);
    rst = 1'b0;
    stray = 0;
    repeat (4) begin
      tick();
      if (m0_ack || m1_ack || mem_write || busy) stray++;
    end
    checkOutput("abort_quiet", 32'(stray), 32'd0);
    checkOutput("abort_mem_untouched", 32'(mem_model[9] === 32'hCAFEF00D), 32'd0);

    $display("[TB] LAT=1 read with early req drop");
    b_m0_req = 1'b1; b_m0_we = 1'b0; b_m0_addr = 32'h10;
    tick();
    checkOutput("l1_read_strobe", 32'(b_mem_read), 32'd1);
    checkOutput("l1_busy_access", 32'(b_busy), 32'd1);
    checkOutput("l1_no_early_ack", 32'(b_m0_ack), 32'd0);
    b_m0_req = 1'b0;
    tick();
    checkOutput("l1_ack", 32'(b_m0_ack), 32'd1);
    checkOutput("l1_rdata", b_m0_rdata, 32'hDEADBEEF);
    checkOutput("l1_read_done", 32'(b_mem_read), 32'd0);
    tick();
    checkOutput("l1_ack_gone", 32'(b_m0_ack), 32'd0);
    checkOutput("l1_busy_idle", 32'(b_busy), 32'd0);

    $display("[TB] LAT=1 write");
    b_m0_req = 1'b1; b_m0_we = 1'b1; b_m0_addr = 32'h28; b_m0_wdata = 32'h0BADCAFE;
    tick();
    checkOutput("l1_write_strobe", 32'(b_mem_write), 32'd1);
    checkOutput("l1_write_noread", 32'(b_mem_read), 32'd0);
    checkOutput("l1_write_addr", b_mem_addr, 32'h28);
    b_m0_req = 1'b0;
    tick();
    checkOutput("l1_write_ack", 32'(b_m0_ack), 32'd1);
    checkOutput("l1_write_rdata_kept", b_m0_rdata, 32'hDEADBEEF);
    tick();
    checkOutput("l1_mem_written", mem_model[10], 32'h0BADCAFE);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
